// File: rtl/fifo_wr_arbiter.sv
// Two-producer round-robin arbiter for a single FIFO write port, with a burst cap
// under contention, a registered write strobe/data and per-producer accept counters.
module fifo_wr_arbiter #(
    parameter int DW        = 8,
    parameter int DEPTH     = 8,
    parameter int CW        = 4,
    parameter int MAX_BURST = 4,
    parameter int SW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          req0_valid,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    input  logic [CW-1:0] fifo_cnt,
    output logic          fifo_wr,
    output logic [DW-1:0] fifo_data,
    output logic          owner,
    output logic [SW-1:0] acc0_cnt,
    output logic [SW-1:0] acc1_cnt
);

    localparam logic [CW:0] DEPTH_C     = (CW+1)'(DEPTH);
    localparam logic [3:0]  MAX_BURST_C = 4'(MAX_BURST);
    localparam logic [3:0]  BURST_SAT_C = 4'd15;

    logic          fifo_wr_r;
    logic [DW-1:0] fifo_data_r;
    logic          owner_r;
    logic [3:0]    burst_cnt_r;
    logic [SW-1:0] acc0_r;
    logic [SW-1:0] acc1_r;

    logic [CW:0]   occ_s;
    logic          space_s;
    logic          elig0_s;
    logic          elig1_s;
    logic          grant0_s;
    logic          grant1_s;
    logic          grant_any_s;

    // The registered push still in flight is counted as occupied.
    assign occ_s       = {1'b0, fifo_cnt} + {{CW{1'b0}}, fifo_wr_r};
    assign space_s     = (occ_s < DEPTH_C);
    assign elig0_s     = en & space_s & req0_valid;
    assign elig1_s     = en & space_s & req1_valid;
    assign grant_any_s = grant0_s | grant1_s;

    // Grant selection: lone requester wins, ties go to owner until the burst cap.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        case ({elig1_s, elig0_s})
            2'b01: grant0_s = 1'b1;
            2'b10: grant1_s = 1'b1;
            2'b11: begin
                if (burst_cnt_r < MAX_BURST_C) begin
                    grant0_s = ~owner_r;
                    grant1_s = owner_r;
                end else begin
                    grant0_s = owner_r;
                    grant1_s = ~owner_r;
                end
            end
            default: begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        endcase
    end

    // Write pipeline: accepted word is pushed to the FIFO on the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_wr_r   <= 1'b0;
            fifo_data_r <= {DW{1'b0}};
        end else begin
            fifo_wr_r <= grant_any_s;
            if (grant_any_s) begin
                fifo_data_r <= grant1_s ? req1_data : req0_data;
            end else begin
                fifo_data_r <= fifo_data_r;
            end
        end
    end

    // Ownership and burst length; burst count saturates so lone streams never wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_r     <= 1'b0;
            burst_cnt_r <= 4'd0;
        end else if (grant_any_s) begin
            if (grant1_s == owner_r) begin
                burst_cnt_r <= (burst_cnt_r == BURST_SAT_C) ? BURST_SAT_C : burst_cnt_r + 4'd1;
            end else begin
                owner_r     <= grant1_s;
                burst_cnt_r <= 4'd1;
            end
        end else begin
            owner_r     <= owner_r;
            burst_cnt_r <= burst_cnt_r;
        end
    end

    // Accept counters wrap naturally at 2^SW.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc0_r <= {SW{1'b0}};
            acc1_r <= {SW{1'b0}};
        end else begin
            if (grant0_s) begin
                acc0_r <= acc0_r + {{(SW-1){1'b0}}, 1'b1};
            end else begin
                acc0_r <= acc0_r;
            end
            if (grant1_s) begin
                acc1_r <= acc1_r + {{(SW-1){1'b0}}, 1'b1};
            end else begin
                acc1_r <= acc1_r;
            end
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign fifo_wr    = fifo_wr_r;
    assign fifo_data  = fifo_data_r;
    assign owner      = owner_r;
    assign acc0_cnt   = acc0_r;
    assign acc1_cnt   = acc1_r;

endmodule
